// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch control slice.
// State encoding, time-field widths and the time bundle struct.
package stopwatch_pkg;

    localparam int MSEC_W = 7;
    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_LAP   = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  min;
        logic [SEC_W-1:0]  sec;
        logic [MSEC_W-1:0] msec;
    } sw_time_t;

endpackage

// File: rtl/lap_capture_reg.sv
// Lap hold registers plus the display mux (held value while frozen, else live).
// Ports: clk, rst (async active-low), i_load, i_clear, i_sel_hold, i_live -> o_disp.
module lap_capture_reg
    import stopwatch_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     i_load,
    input  logic     i_clear,
    input  logic     i_sel_hold,
    input  sw_time_t i_live,
    output sw_time_t o_disp
);

    sw_time_t hold_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q <= '0;
        end else if (i_clear) begin
            hold_q <= '0;
        end else if (i_load) begin
            hold_q <= i_live;
        end
    end

    // Zero-latency bypass of the live time when not frozen.
    assign o_disp = i_sel_hold ? hold_q : i_live;

endmodule

// File: rtl/stopwatch_lap_ctrl.sv
// Run/stop/clear sequencer with lap capture and lap counter.
// Ports: button pulses i_runstop/i_clear/i_lap, live time i_*, datapath controls, display o_*.
module stopwatch_lap_ctrl
    import stopwatch_pkg::*;
#(
    parameter int LAP_MAX = 99,
    parameter int LAP_W   = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_runstop,
    input  logic              i_clear,
    input  logic              i_lap,
    input  logic [MSEC_W-1:0] i_msec,
    input  logic [SEC_W-1:0]  i_sec,
    input  logic [MIN_W-1:0]  i_min,
    input  logic [HOUR_W-1:0] i_hour,
    output logic              o_runstop,
    output logic              o_clear,
    output logic [MSEC_W-1:0] o_msec,
    output logic [SEC_W-1:0]  o_sec,
    output logic [MIN_W-1:0]  o_min,
    output logic [HOUR_W-1:0] o_hour,
    output logic              o_lap_active,
    output logic [LAP_W-1:0]  o_lap_cnt
);

    state_t   state_q;
    state_t   state_d;
    logic     lap_evt;
    logic     clr_evt;
    sw_time_t live;
    sw_time_t disp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_STOP;
        end else begin
            state_q <= state_d;
        end
    end

    // Clear outranks run/stop, which outranks lap; illegal inputs per state are dropped.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_STOP: begin
                if (i_clear) begin
                    state_d = ST_CLEAR;
                end else if (i_runstop) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_runstop) begin
                    state_d = ST_STOP;
                end else if (i_lap) begin
                    state_d = ST_LAP;
                end
            end
            ST_LAP: begin
                if (i_runstop) begin
                    state_d = ST_STOP;
                end else if (i_lap) begin
                    state_d = ST_RUN;
                end
            end
            ST_CLEAR: state_d = ST_STOP;
            default:  state_d = ST_STOP;
        endcase
    end

    assign lap_evt = (state_q == ST_RUN) && (state_d == ST_LAP);
    assign clr_evt = (state_q != ST_CLEAR) && (state_d == ST_CLEAR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_lap_cnt <= '0;
        end else if (clr_evt) begin
            o_lap_cnt <= '0;
        end else if (lap_evt) begin
            if (o_lap_cnt == LAP_W'(LAP_MAX)) begin
                o_lap_cnt <= '0;
            end else begin
                o_lap_cnt <= o_lap_cnt + 1'b1;
            end
        end
    end

    assign o_runstop    = (state_q == ST_RUN) || (state_q == ST_LAP);
    assign o_clear      = (state_q == ST_CLEAR);
    assign o_lap_active = (state_q == ST_LAP);

    assign live = '{hour: i_hour, min: i_min, sec: i_sec, msec: i_msec};

    lap_capture_reg u_lap_capture_reg (
        .clk        (clk),
        .rst        (rst),
        .i_load     (lap_evt),
        .i_clear    (clr_evt),
        .i_sel_hold (o_lap_active),
        .i_live     (live),
        .o_disp     (disp)
    );

    assign o_msec = disp.msec;
    assign o_sec  = disp.sec;
    assign o_min  = disp.min;
    assign o_hour = disp.hour;

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Directed scoreboard bench for stopwatch_lap_ctrl.
// Expected output sets are queued as stimulus is applied and compared after the edge.
module tb_stopwatch_lap_ctrl;

    typedef struct {
        int rs;
        int cl;
        int la;
        int cnt;
        int ms;
        int s;
        int m;
        int h;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       i_runstop;
    logic       i_clear;
    logic       i_lap;
    logic [6:0] i_msec;
    logic [5:0] i_sec;
    logic [5:0] i_min;
    logic [4:0] i_hour;
    logic       o_runstop;
    logic       o_clear;
    logic [6:0] o_msec;
    logic [5:0] o_sec;
    logic [5:0] o_min;
    logic [4:0] o_hour;
    logic       o_lap_active;
    logic [6:0] o_lap_cnt;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    stopwatch_lap_ctrl #(
        .LAP_MAX (99),
        .LAP_W   (7)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_runstop    (i_runstop),
        .i_clear      (i_clear),
        .i_lap        (i_lap),
        .i_msec       (i_msec),
        .i_sec        (i_sec),
        .i_min        (i_min),
        .i_hour       (i_hour),
        .o_runstop    (o_runstop),
        .o_clear      (o_clear),
        .o_msec       (o_msec),
        .o_sec        (o_sec),
        .o_min        (o_min),
        .o_hour       (o_hour),
        .o_lap_active (o_lap_active),
        .o_lap_cnt    (o_lap_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(int rs, int cl, int la, int cnt,
                                int ms, int s, int m, int h);
        exp_t e;
        e.rs = rs; e.cl = cl; e.la = la; e.cnt = cnt;
        e.ms = ms; e.s = s; e.m = m; e.h = h;
        return e;
    endfunction

    task automatic cmp(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_pop();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            cmp("runstop", int'(o_runstop), e.rs);
            cmp("clear", int'(o_clear), e.cl);
            cmp("lap_active", int'(o_lap_active), e.la);
            cmp("lap_cnt", int'(o_lap_cnt), e.cnt);
            cmp("msec", int'(o_msec), e.ms);
            cmp("sec", int'(o_sec), e.s);
            cmp("min", int'(o_min), e.m);
            cmp("hour", int'(o_hour), e.h);
        end
    endtask

    task automatic set_live(input int ms, input int s, input int m, input int h);
        i_msec = 7'(ms);
        i_sec  = 6'(s);
        i_min  = 6'(m);
        i_hour = 5'(h);
    endtask

    task automatic pulse(input logic rs, input logic cl, input logic lp);
        i_runstop = rs;
        i_clear   = cl;
        i_lap     = lp;
        @(posedge clk);
        #1;
        i_runstop = 1'b0;
        i_clear   = 1'b0;
        i_lap     = 1'b0;
    endtask

    task automatic step(input logic rs, input logic cl, input logic lp, input exp_t e);
        sb.push_back(e);
        pulse(rs, cl, lp);
        check_pop();
    endtask

    task automatic peek(input exp_t e);
        sb.push_back(e);
        #1;
        check_pop();
    endtask

    initial begin
        rst       = 1'b0;
        i_runstop = 1'b0;
        i_clear   = 1'b0;
        i_lap     = 1'b0;
        set_live(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        set_live(0, 5, 0, 0);

        // reset state, display follows live
        peek(mk(0, 0, 0, 0, 0, 5, 0, 0));

        // run / stop toggling
        step(1, 0, 0, mk(1, 0, 0, 0, 0, 5, 0, 0));
        step(1, 0, 0, mk(0, 0, 0, 0, 0, 5, 0, 0));

        // lap freeze while live advances
        step(1, 0, 0, mk(1, 0, 0, 0, 0, 5, 0, 0));
        set_live(45, 23, 1, 0);
        step(0, 0, 1, mk(1, 0, 1, 1, 45, 23, 1, 0));
        set_live(50, 24, 1, 0);
        peek(mk(1, 0, 1, 1, 45, 23, 1, 0));
        step(0, 0, 0, mk(1, 0, 1, 1, 45, 23, 1, 0));
        step(0, 0, 1, mk(1, 0, 0, 1, 50, 24, 1, 0));

        // clear ignored in LAP and RUN, then clear from STOP
        step(0, 0, 1, mk(1, 0, 1, 2, 50, 24, 1, 0));
        step(0, 1, 0, mk(1, 0, 1, 2, 50, 24, 1, 0));
        step(0, 0, 1, mk(1, 0, 0, 2, 50, 24, 1, 0));
        step(0, 1, 0, mk(1, 0, 0, 2, 50, 24, 1, 0));
        step(0, 0, 1, mk(1, 0, 1, 3, 50, 24, 1, 0));
        step(1, 0, 0, mk(0, 0, 0, 3, 50, 24, 1, 0));
        step(0, 0, 1, mk(0, 0, 0, 3, 50, 24, 1, 0));
        step(0, 1, 0, mk(0, 1, 0, 0, 50, 24, 1, 0));
        step(0, 0, 0, mk(0, 0, 0, 0, 50, 24, 1, 0));

        // simultaneous pulses
        step(1, 1, 0, mk(0, 1, 0, 0, 50, 24, 1, 0));
        step(0, 0, 0, mk(0, 0, 0, 0, 50, 24, 1, 0));
        step(1, 0, 0, mk(1, 0, 0, 0, 50, 24, 1, 0));
        step(0, 0, 1, mk(1, 0, 1, 1, 50, 24, 1, 0));
        step(0, 0, 1, mk(1, 0, 0, 1, 50, 24, 1, 0));
        step(1, 0, 1, mk(0, 0, 0, 1, 50, 24, 1, 0));

        // lap counter wrap
        step(1, 0, 0, mk(1, 0, 0, 1, 50, 24, 1, 0));
        for (int i = 0; i < 98; i++) begin
            pulse(0, 0, 1);
            pulse(0, 0, 1);
        end
        peek(mk(1, 0, 0, 99, 50, 24, 1, 0));
        set_live(7, 8, 9, 10);
        step(0, 0, 1, mk(1, 0, 1, 0, 7, 8, 9, 10));

        // async reset while in LAP, no clock edge
        set_live(11, 12, 13, 14);
        #2;
        rst = 1'b0;
        peek(mk(0, 0, 0, 0, 11, 12, 13, 14));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
